// File: rtl/mem_arb_pkg.sv
// Shared constants for mem_arbiter: FSM encodings, channel-count limit and grant width helper.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t RESP = 2'd2;

  localparam int MAX_CH = 8;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: first set request at or above ptr_i, wrapping at N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  always_comb begin
    req2 = {req_i, req_i} >> ptr_i;
    rot  = req2[N-1:0];
    off  = '0;
    // Descending scan so the smallest offset from the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx_o   = sum[W-1:0];
    valid_o = |req_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-organised memory port among NUM_CH cache channels (READ/WRITE/BUSYWAIT).
// Define MEM_ARB_RR_EN for round-robin selection; otherwise the lowest index wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [NUM_CH-1:0]        CH_READ,
  input  logic [NUM_CH-1:0]        CH_WRITE,
  input  logic [NUM_CH*ADDR_W-1:0] CH_ADDRESS,
  input  logic [NUM_CH*DATA_W-1:0] CH_WRITEDATA,
  output logic [DATA_W-1:0]        CH_READDATA,
  output logic [NUM_CH-1:0]        CH_BUSYWAIT,
  output logic                     MEM_READ,
  output logic                     MEM_WRITE,
  output logic [ADDR_W-1:0]        MEM_ADDRESS,
  output logic [DATA_W-1:0]        MEM_WRITEDATA,
  input  logic [DATA_W-1:0]        MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  localparam int GW = grant_w(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("mem_arbiter: NUM_CH out of range");
  end

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic [NUM_CH-1:0] req;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     pick_idx;
  logic              pick_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  assign req = CH_READ | CH_WRITE;

`ifdef MEM_ARB_RR_EN
  logic [GW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_pick #(
    .N (NUM_CH),
    .W (GW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_addr  = CH_ADDRESS[i*ADDR_W +: ADDR_W];
        sel_wdata = CH_WRITEDATA[i*DATA_W +: DATA_W];
        sel_write = CH_WRITE[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // A write outranks a simultaneous read on the same channel.
          wr_d    = sel_write;
          rd_d    = ~sel_write;
          state_d = BUSY;
`ifdef MEM_ARB_RR_EN
          ptr_d   = (pick_idx == GW'(NUM_CH - 1)) ? '0 : pick_idx + GW'(1);
`endif
        end
      end
      BUSY: begin
        if (!MEM_BUSYWAIT) begin
          if (rd_q) rdata_d = MEM_READDATA;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Stall is combinational on req so a fresh request is held off in its own cycle.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_busywait
    assign CH_BUSYWAIT[gi] = req[gi] & ~((state_q == RESP) && (grant_q == GW'(gi)));
  end

  assign CH_READDATA   = rdata_q;
  assign MEM_READ      = rd_q;
  assign MEM_WRITE     = wr_q;
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a fixed-latency block memory model and a transaction scoreboard.
module tb_mem_arbiter;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 128;
  localparam int LAT    = 5;
  localparam int TMO    = 200;

  logic                     CLK;
  logic                     RESET_N;
  logic [NUM_CH-1:0]        CH_READ;
  logic [NUM_CH-1:0]        CH_WRITE;
  logic [NUM_CH*ADDR_W-1:0] CH_ADDRESS;
  logic [NUM_CH*DATA_W-1:0] CH_WRITEDATA;
  logic [DATA_W-1:0]        CH_READDATA;
  logic [NUM_CH-1:0]        CH_BUSYWAIT;
  logic                     MEM_READ;
  logic                     MEM_WRITE;
  logic [ADDR_W-1:0]        MEM_ADDRESS;
  logic [DATA_W-1:0]        MEM_WRITEDATA;
  logic [DATA_W-1:0]        MEM_READDATA;
  logic                     MEM_BUSYWAIT;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mtx_t;

  mtx_t exp_q[$];
  mtx_t obs_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [DATA_W-1:0] last_rd = '0;

  localparam logic [DATA_W-1:0] PAT_A5   = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_BEEF = 128'hDEAD_BEEF;
  localparam logic [DATA_W-1:0] PAT_RW   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  mem_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .CH_READ       (CH_READ),
    .CH_WRITE      (CH_WRITE),
    .CH_ADDRESS    (CH_ADDRESS),
    .CH_WRITEDATA  (CH_WRITEDATA),
    .CH_READDATA   (CH_READDATA),
    .CH_BUSYWAIT   (CH_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DATA_W-1:0] init_pat(input logic [ADDR_W-1:0] a);
    if (a == 6'h05) return PAT_A5;
    return {4{24'hC0DE00, 2'b00, a}};
  endfunction

  // Block memory model: busywait rises with the strobe and falls in the LAT-th strobe cycle.
  logic [DATA_W-1:0] mem [64];
  bit mem_ready = 1'b0;
  int lat_cnt   = 0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (lat_cnt != LAT - 1);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_pat(ADDR_W'(i));
      mem_ready <= 1'b1;
    end else if (MEM_READ | MEM_WRITE) begin
      if (MEM_BUSYWAIT) lat_cnt <= lat_cnt + 1;
      else begin
        lat_cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  always @(negedge CLK) begin
    if (RESET_N && (MEM_READ | MEM_WRITE) && !MEM_BUSYWAIT)
      obs_q.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
  end

  task automatic test_reset();
    RESET_N = 1'b0; CH_READ = '0; CH_WRITE = '0; CH_ADDRESS = '0; CH_WRITEDATA = '0;
    repeat (3) @(negedge CLK);
    n_total++; if (MEM_READ !== 1'b0) $display("FAIL rst_mem_read: got %b expected 0", MEM_READ); else n_pass++;
    n_total++; if (MEM_WRITE !== 1'b0) $display("FAIL rst_mem_write: got %b expected 0", MEM_WRITE); else n_pass++;
    n_total++; if (MEM_ADDRESS !== '0) $display("FAIL rst_mem_addr: got %h expected 0", MEM_ADDRESS); else n_pass++;
    n_total++; if (MEM_WRITEDATA !== '0) $display("FAIL rst_mem_wdata: got %h expected 0", MEM_WRITEDATA); else n_pass++;
    n_total++; if (CH_READDATA !== '0) $display("FAIL rst_readdata: got %h expected 0", CH_READDATA); else n_pass++;
    n_total++; if (CH_BUSYWAIT !== 2'b00) $display("FAIL rst_busywait_idle: got %b expected 00", CH_BUSYWAIT); else n_pass++;
    CH_WRITE = 2'b10;
    #1;
    n_total++; if (CH_BUSYWAIT !== 2'b10) $display("FAIL rst_busywait_req: got %b expected 10", CH_BUSYWAIT); else n_pass++;
    CH_WRITE = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    $display("reset: done");
  endtask

  task automatic test_single_read();
    int hi = 0, cyc = 0;
    bit done = 0;
    CH_ADDRESS[0 +: ADDR_W] = 6'h05;
    CH_READ[0] = 1'b1;
    exp_q.push_back('{1'b0, 6'h05, '0});
    #1;
    n_total++; if (CH_BUSYWAIT[0] !== 1'b1) $display("FAIL rd_stall_immediate: got %b expected 1", CH_BUSYWAIT[0]); else n_pass++;
    while (!done && cyc < TMO) begin
      @(negedge CLK); cyc++;
      if (MEM_READ) hi++;
      if (!CH_BUSYWAIT[0]) done = 1;
    end
    n_total++; if (done !== 1'b1) $display("FAIL rd_timeout: got %0d expected 1", done); else n_pass++;
    n_total++; if (hi != LAT) $display("FAIL rd_strobe_cycles: got %0d expected %0d", hi, LAT); else n_pass++;
    n_total++; if (CH_READDATA !== PAT_A5) $display("FAIL rd_data: got %h expected %h", CH_READDATA, PAT_A5); else n_pass++;
    n_total++; if (MEM_READ !== 1'b0) $display("FAIL rd_strobe_in_resp: got %b expected 0", MEM_READ); else n_pass++;
    last_rd = PAT_A5;
    @(negedge CLK);
    n_total++; if (CH_BUSYWAIT[0] !== 1'b1) $display("FAIL rd_busywait_one_cycle: got %b expected 1", CH_BUSYWAIT[0]); else n_pass++;
    CH_READ[0] = 1'b0;
    repeat (2) @(negedge CLK);
    $display("single_read: ch0 addr 05 strobe %0d cycles data %h", hi, CH_READDATA);
  endtask

  task automatic test_contention();
    int n = 0, cyc = 0, g, exp_g;
    logic [ADDR_W-1:0] ch_addr [2];
    ch_addr[0] = 6'h01; ch_addr[1] = 6'h02;
    for (int k = 0; k < 5; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (k < 4) ? (k % 2) : 1;
`else
      exp_g = (k < 4) ? 0 : 1;
`endif
      exp_q.push_back('{1'b0, ch_addr[exp_g], '0});
    end
    CH_ADDRESS = {ch_addr[1], ch_addr[0]};
    CH_READ = 2'b11;
    while (n < 5 && cyc < TMO) begin
      @(negedge CLK); cyc++;
      g = -1;
      for (int c = 0; c < NUM_CH; c++) if (CH_READ[c] && !CH_BUSYWAIT[c]) g = c;
      if (g >= 0) begin
`ifdef MEM_ARB_RR_EN
        exp_g = (n < 4) ? (n % 2) : 1;
`else
        exp_g = (n < 4) ? 0 : 1;
`endif
        n_total++; if (g != exp_g) $display("FAIL cont_grant%0d: got %0d expected %0d", n, g, exp_g); else n_pass++;
        n_total++; if (CH_READDATA !== init_pat(ch_addr[exp_g])) $display("FAIL cont_data%0d: got %h expected %h", n, CH_READDATA, init_pat(ch_addr[exp_g])); else n_pass++;
        if (n < 4) begin
          n_total++; if (CH_BUSYWAIT[1-exp_g] !== 1'b1) $display("FAIL cont_other_stalled%0d: got %b expected 1", n, CH_BUSYWAIT[1-exp_g]); else n_pass++;
        end
        $display("contention: completion %0d granted ch%0d data %h", n, g, CH_READDATA);
        last_rd = init_pat(ch_addr[exp_g]);
        n++;
        if (n == 4) CH_READ[0] = 1'b0;
        if (n == 5) CH_READ[1] = 1'b0;
      end
    end
    n_total++; if (n != 5) $display("FAIL cont_timeout: got %0d expected 5", n); else n_pass++;
    CH_READ = '0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_write_then_read();
    int wr_hi = 0, bad = 0, cyc = 0;
    bit done = 0;
    CH_ADDRESS[ADDR_W +: ADDR_W] = 6'h3A;
    CH_WRITEDATA[DATA_W +: DATA_W] = PAT_BEEF;
    CH_WRITE[1] = 1'b1;
    exp_q.push_back('{1'b1, 6'h3A, PAT_BEEF});
    while (!done && cyc < TMO) begin
      @(negedge CLK); cyc++;
      if (MEM_WRITE) begin
        wr_hi++;
        if (MEM_WRITEDATA !== PAT_BEEF || MEM_READ !== 1'b0) bad++;
      end
      if (!CH_BUSYWAIT[1]) done = 1;
    end
    n_total++; if (done !== 1'b1) $display("FAIL wr_timeout: got %0d expected 1", done); else n_pass++;
    n_total++; if (wr_hi != LAT) $display("FAIL wr_strobe_cycles: got %0d expected %0d", wr_hi, LAT); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL wr_mem_wdata: got %0d bad cycles expected 0", bad); else n_pass++;
    n_total++; if (CH_READDATA !== last_rd) $display("FAIL wr_readdata_kept: got %h expected %h", CH_READDATA, last_rd); else n_pass++;
    $display("write: ch1 addr 3a data %h strobe %0d cycles", PAT_BEEF, wr_hi);
    CH_WRITE[1] = 1'b0;
    repeat (2) @(negedge CLK);
    done = 0; cyc = 0;
    CH_ADDRESS[0 +: ADDR_W] = 6'h3A;
    CH_READ[0] = 1'b1;
    exp_q.push_back('{1'b0, 6'h3A, '0});
    while (!done && cyc < TMO) begin
      @(negedge CLK); cyc++;
      if (!CH_BUSYWAIT[0]) done = 1;
    end
    n_total++; if (done !== 1'b1) $display("FAIL wr_rd_timeout: got %0d expected 1", done); else n_pass++;
    n_total++; if (CH_READDATA !== PAT_BEEF) $display("FAIL wr_readback: got %h expected %h", CH_READDATA, PAT_BEEF); else n_pass++;
    $display("read: ch0 addr 3a data %h", CH_READDATA);
    last_rd = PAT_BEEF;
    CH_READ[0] = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_rw_both();
    int wr_hi = 0, rd_hi = 0, cyc = 0;
    bit done = 0;
    CH_ADDRESS[ADDR_W +: ADDR_W] = 6'h10;
    CH_WRITEDATA[DATA_W +: DATA_W] = PAT_RW;
    CH_READ[1] = 1'b1;
    CH_WRITE[1] = 1'b1;
    exp_q.push_back('{1'b1, 6'h10, PAT_RW});
    while (!done && cyc < TMO) begin
      @(negedge CLK); cyc++;
      if (MEM_WRITE) wr_hi++;
      if (MEM_READ) rd_hi++;
      if (!CH_BUSYWAIT[1]) done = 1;
    end
    n_total++; if (done !== 1'b1) $display("FAIL rw_timeout: got %0d expected 1", done); else n_pass++;
    n_total++; if (rd_hi != 0) $display("FAIL rw_no_read: got %0d read cycles expected 0", rd_hi); else n_pass++;
    n_total++; if (wr_hi != LAT) $display("FAIL rw_write_cycles: got %0d expected %0d", wr_hi, LAT); else n_pass++;
    n_total++; if (CH_READDATA !== last_rd) $display("FAIL rw_readdata_kept: got %h expected %h", CH_READDATA, last_rd); else n_pass++;
    $display("rw_both: ch1 addr 10 write cycles %0d read cycles %0d", wr_hi, rd_hi);
    CH_READ[1] = 1'b0;
    CH_WRITE[1] = 1'b0;
    repeat (2) @(negedge CLK);
    done = 0; cyc = 0;
    CH_ADDRESS[0 +: ADDR_W] = 6'h10;
    CH_READ[0] = 1'b1;
    exp_q.push_back('{1'b0, 6'h10, '0});
    while (!done && cyc < TMO) begin
      @(negedge CLK); cyc++;
      if (!CH_BUSYWAIT[0]) done = 1;
    end
    n_total++; if (CH_READDATA !== PAT_RW) $display("FAIL rw_readback: got %h expected %h", CH_READDATA, PAT_RW); else n_pass++;
    $display("read: ch0 addr 10 data %h", CH_READDATA);
    last_rd = PAT_RW;
    CH_READ[0] = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid_busy();
    int hi = 0, cyc = 0;
    bit done = 0;
    CH_ADDRESS[0 +: ADDR_W] = 6'h05;
    CH_READ[0] = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++; if (MEM_READ !== 1'b1) $display("FAIL rmb_busy_before: got %b expected 1", MEM_READ); else n_pass++;
    RESET_N = 1'b0;
    #1;
    n_total++; if (MEM_READ !== 1'b0) $display("FAIL rmb_strobe_cleared: got %b expected 0", MEM_READ); else n_pass++;
    n_total++; if (CH_READDATA !== '0) $display("FAIL rmb_readdata_cleared: got %h expected 0", CH_READDATA); else n_pass++;
    n_total++; if (CH_BUSYWAIT[0] !== 1'b1) $display("FAIL rmb_still_stalled: got %b expected 1", CH_BUSYWAIT[0]); else n_pass++;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    exp_q.push_back('{1'b0, 6'h05, '0});
    while (!done && cyc < TMO) begin
      @(negedge CLK); cyc++;
      if (MEM_READ) hi++;
      if (!CH_BUSYWAIT[0]) done = 1;
    end
    n_total++; if (done !== 1'b1) $display("FAIL rmb_timeout: got %0d expected 1", done); else n_pass++;
    n_total++; if (hi != LAT) $display("FAIL rmb_strobe_cycles: got %0d expected %0d", hi, LAT); else n_pass++;
    n_total++; if (CH_READDATA !== PAT_A5) $display("FAIL rmb_data: got %h expected %h", CH_READDATA, PAT_A5); else n_pass++;
    $display("reset_mid_busy: restarted read data %h strobe %0d cycles", CH_READDATA, hi);
    CH_READ[0] = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_scoreboard();
    mtx_t e, o;
    int idx = 0;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++; if (o.w !== e.w || o.addr !== e.addr) $display("FAIL sb_op%0d: got w=%b addr=%h expected w=%b addr=%h", idx, o.w, o.addr, e.w, e.addr); else n_pass++;
      if (e.w) begin
        n_total++; if (o.wdata !== e.wdata) $display("FAIL sb_wdata%0d: got %h expected %h", idx, o.wdata, e.wdata); else n_pass++;
      end
      $display("scoreboard: txn %0d w=%b addr=%h", idx, o.w, o.addr);
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_rw_both();
    test_reset_mid_busy();
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
